// File: rtl/mlp_trainer_pkg.sv
// Shared types and signed fixed-point (Q8.8, 16-bit) helpers for the MLP trainer.
// All arithmetic saturates to [SFP_MIN, SFP_MAX] instead of wrapping.
package mlp_trainer_pkg;

  localparam int SFP_W = 16;
  localparam logic signed [SFP_W-1:0] SFP_MAX = 16'sh7FFF;
  localparam logic signed [SFP_W-1:0] SFP_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_STEP,
    ST_EMIT,
    ST_NEXT,
    ST_FIN
  } trainer_state_e;

  function automatic logic signed [SFP_W-1:0] sfp_clamp(input logic signed [SFP_W:0] x);
    if (x > SFP_MAX) return SFP_MAX;
    else if (x < SFP_MIN) return SFP_MIN;
    else return x[SFP_W-1:0];
  endfunction

  function automatic logic signed [SFP_W-1:0] sfp_add_sat(input logic signed [SFP_W-1:0] a,
                                                          input logic signed [SFP_W-1:0] b);
    logic signed [SFP_W:0] s;
    s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
    return sfp_clamp(s);
  endfunction

  function automatic logic signed [SFP_W-1:0] sfp_sub_sat(input logic signed [SFP_W-1:0] a,
                                                          input logic signed [SFP_W-1:0] b);
    logic signed [SFP_W:0] s;
    s = {a[SFP_W-1], a} - {b[SFP_W-1], b};
    return sfp_clamp(s);
  endfunction

  // |SFP_MIN| is not representable, so it folds onto SFP_MAX.
  function automatic logic signed [SFP_W-1:0] sfp_abs(input logic signed [SFP_W-1:0] a);
    if (a == SFP_MIN) return SFP_MAX;
    else if (a < 0) return -a;
    else return a;
  endfunction

endpackage

// File: rtl/mlp_trainer_sample_mem.sv
// Sample/label store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded data set survives a run abort.
module mlp_sample_mem #(
  parameter int SAMPLES = 4,
  parameter int ENTRY_W = 48,
  parameter int AW      = 2
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [SAMPLES];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mlp_trainer.sv
// Sequencer that streams stored samples into an MLP, strobes weight updates in
// training mode, returns predictions in inference mode, and tracks per-epoch loss.
module mlp_trainer
  import mlp_trainer_pkg::*;
#(
  parameter int INPUTS        = 2,
  parameter int OUTPUTS       = 1,
  parameter int SAMPLES       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int EPOCH_W       = 16,
  localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
  localparam int VW = INPUTS * SFP_W,
  localparam int EW = OUTPUTS * SFP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [AW-1:0]      load_addr,
  input  logic [VW-1:0]      load_values,
  input  logic [EW-1:0]      load_expected,
  input  logic               start,
  input  logic               train_mode,
  input  logic [EPOCH_W-1:0] num_epochs,
  output logic [VW-1:0]      mlp_values,
  output logic [EW-1:0]      mlp_expected,
  output logic               mlp_training,
  input  logic [EW-1:0]      mlp_prediction,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [AW-1:0]      res_index,
  output logic [EW-1:0]      res_prediction,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [SFP_W-1:0]   epoch_loss
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  trainer_state_e          state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [EPOCH_W-1:0]      epoch_count_q, epoch_count_d;
  logic [EPOCH_W-1:0]      num_epochs_q, num_epochs_d;
  logic                    train_q, train_d;
  logic signed [SFP_W-1:0] acc_q, acc_d;
  logic signed [SFP_W-1:0] loss_q, loss_d;
  logic [VW-1:0]           vals_q, vals_d;
  logic [EW-1:0]           exp_q, exp_d;
  logic [EW-1:0]           res_pred_q, res_pred_d;
  logic [VW+EW-1:0]        rd_data;
  logic signed [SFP_W-1:0] sample_err;
  logic [EPOCH_W-1:0]      eff_epochs;

  mlp_sample_mem #(
    .SAMPLES(SAMPLES),
    .ENTRY_W(VW + EW),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (load_valid && (state_q == ST_IDLE)),
    .waddr_i(load_addr),
    .wdata_i({load_values, load_expected}),
    .raddr_i(idx_q),
    .rdata_o(rd_data)
  );

  // Sum of per-output absolute errors for the sample currently on the bus.
  always_comb begin
    sample_err = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      sample_err = sfp_add_sat(sample_err,
                     sfp_abs(sfp_sub_sat($signed(exp_q[o*SFP_W +: SFP_W]),
                                         $signed(mlp_prediction[o*SFP_W +: SFP_W]))));
    end
  end

  assign eff_epochs = train_mode ? num_epochs : EPOCH_W'(1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    settle_d      = settle_q;
    epoch_count_d = epoch_count_q;
    num_epochs_d  = num_epochs_q;
    train_d       = train_q;
    acc_d         = acc_q;
    loss_d        = loss_q;
    vals_d        = vals_q;
    exp_d         = exp_q;
    res_pred_d    = res_pred_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          train_d       = train_mode;
          num_epochs_d  = eff_epochs;
          idx_d         = '0;
          epoch_count_d = '0;
          acc_d         = '0;
          state_d       = (eff_epochs == '0) ? ST_FIN : ST_APPLY;
        end
      end
      ST_APPLY: begin
        vals_d   = rd_data[VW+EW-1:EW];
        exp_d    = rd_data[EW-1:0];
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          acc_d = sfp_add_sat(acc_q, sample_err);
          if (!train_q) res_pred_d = mlp_prediction;
          state_d = train_q ? ST_STEP : ST_EMIT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_STEP: state_d = ST_NEXT;
      ST_EMIT: begin
        if (res_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == AW'(SAMPLES - 1)) begin
          idx_d         = '0;
          loss_d        = acc_q;
          acc_d         = '0;
          epoch_count_d = epoch_count_q + EPOCH_W'(1);
          state_d       = (epoch_count_d == num_epochs_q) ? ST_FIN : ST_APPLY;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_APPLY;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      epoch_count_q <= '0;
      num_epochs_q  <= '0;
      train_q       <= 1'b0;
      acc_q         <= '0;
      loss_q        <= '0;
      vals_q        <= '0;
      exp_q         <= '0;
      res_pred_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      settle_q      <= settle_d;
      epoch_count_q <= epoch_count_d;
      num_epochs_q  <= num_epochs_d;
      train_q       <= train_d;
      acc_q         <= acc_d;
      loss_q        <= loss_d;
      vals_q        <= vals_d;
      exp_q         <= exp_d;
      res_pred_q    <= res_pred_d;
    end
  end

  assign load_ready     = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FIN);
  assign mlp_training   = (state_q == ST_STEP);
  assign res_valid      = (state_q == ST_EMIT);
  assign res_index      = idx_q;
  assign res_prediction = res_pred_q;
  assign mlp_values     = vals_q;
  assign mlp_expected   = exp_q;
  assign epoch_count    = epoch_count_q;
  assign epoch_loss     = loss_q;

endmodule
